// File: rtl/hfrv_arb_pkg.sv
// Shared types and constants for the HF-RISC data-memory arbiter.
package hfrv_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } arb_owner_e;

  localparam int LAT_MAX = 15;
  localparam int CNT_W   = 4;

endpackage

// File: rtl/hfrv_arb_sel.sv
// Two-way winner selector for the memory arbiter.
// HFRV_ARB_RR_EN selects round-robin on ties; otherwise the CPU has fixed priority.
module hfrv_arb_sel
  import hfrv_arb_pkg::*;
(
  input  logic       cpu_req,
  input  logic       dma_req,
  input  arb_owner_e last_owner,
  output logic       req_any,
  output arb_owner_e winner
);

`ifndef HFRV_ARB_RR_EN
  logic sel_unused_s;
  assign sel_unused_s = last_owner;
`endif

  // Winner decode; on a tie round-robin favours whoever did not go last
  always_comb begin
    req_any = cpu_req | dma_req;
`ifdef HFRV_ARB_RR_EN
    if (cpu_req && dma_req) begin
      winner = (last_owner == OWN_CPU) ? OWN_DMA : OWN_CPU;
    end else if (dma_req) begin
      winner = OWN_DMA;
    end else begin
      winner = OWN_CPU;
    end
`else
    if (cpu_req) begin
      winner = OWN_CPU;
    end else if (dma_req) begin
      winner = OWN_DMA;
    end else begin
      winner = OWN_CPU;
    end
`endif
  end

endmodule

// File: rtl/hfrv_mem_arbiter.sv
// Shares the single HF-RISC data-memory port between the CPU and a DMA master,
// one transaction at a time. Tie policy set by HFRV_ARB_RR_EN (see hfrv_arb_sel).
module hfrv_mem_arbiter
  import hfrv_arb_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_access,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_data_write,
  input  logic [3:0]  cpu_data_we,
  output logic [31:0] cpu_data_read,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic [31:0] dma_address,
  input  logic [31:0] dma_wdata,
  input  logic [3:0]  dma_we,
  output logic        dma_gnt,
  output logic [31:0] dma_rdata,
  output logic        dma_rvalid,
  output logic        mem_access,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_write,
  output logic [3:0]  mem_data_we,
  input  logic [31:0] mem_data_read
);

  if (MEM_LAT < 1 || MEM_LAT > LAT_MAX) begin : g_lat_chk
    $error("hfrv_mem_arbiter: MEM_LAT must be within 1..15");
  end

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

  arb_state_e       state_r, state_s;
  arb_owner_e       owner_r, winner_s;
  logic             req_any_s;
  logic [CNT_W-1:0] cnt_r;
  logic             mem_access_r;
  logic [31:0]      mem_address_r, mem_data_write_r;
  logic [3:0]       mem_data_we_r;
  logic [31:0]      cpu_data_read_r, dma_rdata_r;
  logic             dma_rvalid_r;

  hfrv_arb_sel u_sel (
    .cpu_req    (cpu_access),
    .dma_req    (dma_req),
    .last_owner (owner_r),
    .req_any    (req_any_s),
    .winner     (winner_s)
  );

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_any_s) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: state_s = WAIT;
      WAIT: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = DONE;
        end else begin
          state_s = WAIT;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, latched command (held in the mem_* registers for the ISSUE cycle) and read capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r          <= IDLE;
      owner_r          <= OWN_DMA;
      cnt_r            <= {CNT_W{1'b0}};
      mem_access_r     <= 1'b0;
      mem_address_r    <= 32'h0;
      mem_data_write_r <= 32'h0;
      mem_data_we_r    <= 4'h0;
      cpu_data_read_r  <= 32'h0;
      dma_rdata_r      <= 32'h0;
      dma_rvalid_r     <= 1'b0;
    end else begin
      state_r          <= state_s;
      mem_access_r     <= 1'b0;
      mem_address_r    <= 32'h0;
      mem_data_write_r <= 32'h0;
      mem_data_we_r    <= 4'h0;
      dma_rvalid_r     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_any_s) begin
            owner_r      <= winner_s;
            mem_access_r <= 1'b1;
            if (winner_s == OWN_CPU) begin
              mem_address_r    <= cpu_address;
              mem_data_write_r <= cpu_data_write;
              mem_data_we_r    <= cpu_data_we;
            end else begin
              mem_address_r    <= dma_address;
              mem_data_write_r <= dma_wdata;
              mem_data_we_r    <= dma_we;
            end
          end
        end
        ISSUE: cnt_r <= LAT_LOAD;
        WAIT: begin
          if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end else if (owner_r == OWN_CPU) begin
            cpu_data_read_r <= mem_data_read;
          end else begin
            dma_rdata_r  <= mem_data_read;
            dma_rvalid_r <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dma_gnt        = (state_r == IDLE) && req_any_s && (winner_s == OWN_DMA);
  assign cpu_stall      = cpu_access && !((state_r == DONE) && (owner_r == OWN_CPU));
  assign cpu_data_read  = cpu_data_read_r;
  assign dma_rdata      = dma_rdata_r;
  assign dma_rvalid     = dma_rvalid_r;
  assign mem_access     = mem_access_r;
  assign mem_address    = mem_address_r;
  assign mem_data_write = mem_data_write_r;
  assign mem_data_we    = mem_data_we_r;

endmodule

// File: tb/tb_hfrv_mem_arbiter.sv
// Directed bench for hfrv_mem_arbiter: three instances at MEM_LAT 1, 3 and 15.
module tb_hfrv_mem_arbiter;

  localparam int LATS [3] = '{1, 3, 15};

  typedef struct {
    int          dut;
    bit          is_dma;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  int          sel;
  logic        cpu_access, dma_req;
  logic [31:0] cpu_address, cpu_data_write, dma_address, dma_wdata;
  logic [3:0]  cpu_data_we, dma_we;

  logic [2:0]        cpu_stall_a, dma_gnt_a, dma_rvalid_a, mem_acc_a;
  logic [2:0][31:0]  cpu_rd_a, dma_rd_a, mem_addr_a, mem_wd_a, mem_rd_a;
  logic [2:0][3:0]   mem_we_a;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    int          mcnt = 0;
    logic [31:0] mval = 32'h0;

    hfrv_mem_arbiter #(.MEM_LAT(LATS[g])) u_dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .cpu_access     (cpu_access && (sel == g)),
      .cpu_address    (cpu_address),
      .cpu_data_write (cpu_data_write),
      .cpu_data_we    (cpu_data_we),
      .cpu_data_read  (cpu_rd_a[g]),
      .cpu_stall      (cpu_stall_a[g]),
      .dma_req        (dma_req && (sel == g)),
      .dma_address    (dma_address),
      .dma_wdata      (dma_wdata),
      .dma_we         (dma_we),
      .dma_gnt        (dma_gnt_a[g]),
      .dma_rdata      (dma_rd_a[g]),
      .dma_rvalid     (dma_rvalid_a[g]),
      .mem_access     (mem_acc_a[g]),
      .mem_address    (mem_addr_a[g]),
      .mem_data_write (mem_wd_a[g]),
      .mem_data_we    (mem_we_a[g]),
      .mem_data_read  (mem_rd_a[g])
    );

    // Memory model: data is valid only in the single cycle MEM_LAT after the strobe
    always @(posedge clk) begin
      if (mem_acc_a[g]) begin
        mcnt <= LATS[g];
        mval <= pat(mem_addr_a[g]);
      end else if (mcnt != 0) begin
        mcnt <= mcnt - 1;
      end
    end
    assign mem_rd_a[g] = (mcnt == 1) ? mval : 32'h0BAD0BAD;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input int d);
    chk("rst_mem_access", 32'(mem_acc_a[d]), 32'h0);
    chk("rst_mem_address", mem_addr_a[d], 32'h0);
    chk("rst_mem_we", 32'(mem_we_a[d]), 32'h0);
    chk("rst_mem_wdata", mem_wd_a[d], 32'h0);
    chk("rst_cpu_data_read", cpu_rd_a[d], 32'h0);
    chk("rst_dma_rdata", dma_rd_a[d], 32'h0);
    chk("rst_dma_rvalid", 32'(dma_rvalid_a[d]), 32'h0);
    chk("rst_dma_gnt", 32'(dma_gnt_a[d]), 32'h0);
  endtask

  // One complete transaction on instance v.dut, checked every cycle from 0 to 2+MEM_LAT
  task automatic run_row(input vec_t v);
    int L;
    int d;
    L   = LATS[v.dut];
    d   = v.dut;
    sel = v.dut;
    if (v.is_dma) begin
      dma_req = 1'b1; dma_address = v.addr; dma_wdata = v.wdata; dma_we = v.we;
    end else begin
      cpu_access = 1'b1; cpu_address = v.addr; cpu_data_write = v.wdata; cpu_data_we = v.we;
    end
    for (int c = 0; c <= 2 + L; c++) begin
      @(negedge clk);
      chk("stall", 32'(cpu_stall_a[d]), 32'(!v.is_dma && c <= 1 + L));
      chk("dma_gnt", 32'(dma_gnt_a[d]), 32'(v.is_dma && c == 0));
      chk("dma_rvalid", 32'(dma_rvalid_a[d]), 32'(v.is_dma && c == 2 + L));
      chk("mem_access", 32'(mem_acc_a[d]), 32'(c == 1));
      chk("mem_address", mem_addr_a[d], (c == 1) ? v.addr : 32'h0);
      chk("mem_we", 32'(mem_we_a[d]), (c == 1) ? 32'(v.we) : 32'h0);
      chk("mem_wdata", mem_wd_a[d], (c == 1) ? v.wdata : 32'h0);
      if (c == 2 + L && v.we == 4'h0) begin
        if (v.is_dma) chk("dma_rdata", dma_rd_a[d], v.rdata);
        else          chk("cpu_data_read", cpu_rd_a[d], v.rdata);
      end
      @(posedge clk); #1;
      if (v.is_dma && c == 0) begin
        dma_req = 1'b0; dma_address = 32'hFFFF_FFFC; dma_wdata = 32'hFFFF_FFFF; dma_we = 4'hF;
      end
      if (!v.is_dma && c == 2 + L) cpu_access = 1'b0;
    end
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  vec_t vecs [7];
  vec_t post_rst;
  logic [11:0] tie_stall, tie_gnt, tie_rv;
  logic [31:0] tie_addr5;

  initial begin
    reset_n = 1'b0; sel = 0;
    cpu_access = 1'b0; cpu_address = 32'h0; cpu_data_write = 32'h0; cpu_data_we = 4'h0;
    dma_req = 1'b0; dma_address = 32'h0; dma_wdata = 32'h0; dma_we = 4'h0;

    vecs[0] = '{dut: 0, is_dma: 1'b0, addr: 32'h100, we: 4'h0, wdata: 32'h0,        rdata: 32'hDEADBEEF};
    vecs[1] = '{dut: 1, is_dma: 1'b1, addr: 32'h40,  we: 4'hF, wdata: 32'h12345678, rdata: 32'h0};
    vecs[2] = '{dut: 1, is_dma: 1'b1, addr: 32'h80,  we: 4'h0, wdata: 32'h0,        rdata: 32'h0080FF7F};
    vecs[3] = '{dut: 1, is_dma: 1'b0, addr: 32'h104, we: 4'h0, wdata: 32'h0,        rdata: 32'h0104FEFB};
    vecs[4] = '{dut: 2, is_dma: 1'b0, addr: 32'h200, we: 4'h2, wdata: 32'h0000AB00, rdata: 32'h0};
    vecs[5] = '{dut: 0, is_dma: 1'b1, addr: 32'h3C,  we: 4'h0, wdata: 32'h0,        rdata: 32'h003CFFC3};
    vecs[6] = '{dut: 2, is_dma: 1'b1, addr: 32'h10,  we: 4'h0, wdata: 32'h0,        rdata: 32'h0010FFEF};
    post_rst = '{dut: 1, is_dma: 1'b0, addr: 32'h108, we: 4'h0, wdata: 32'h0,      rdata: 32'h0108FEF7};

`ifdef HFRV_ARB_RR_EN
    tie_stall = 12'b0111_1111_0111;
    tie_gnt   = 12'b0000_0001_0000;
    tie_rv    = 12'b0000_1000_0000;
    tie_addr5 = 32'h3A0;
`else
    tie_stall = 12'b0111_0111_0111;
    tie_gnt   = 12'b0000_0000_0000;
    tie_rv    = 12'b0000_0000_0000;
    tie_addr5 = 32'h300;
`endif

    // reset state on every instance
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk_idle_outputs(d);
      chk("rst_stall", 32'(cpu_stall_a[d]), 32'h0);
    end
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_row(vecs[i]);

    // reset during WAIT of a DMA read on the MEM_LAT=3 instance
    sel = 1; dma_req = 1'b1; dma_address = 32'h84; dma_we = 4'h0; dma_wdata = 32'h0;
    @(negedge clk);
    chk("abort_gnt", 32'(dma_gnt_a[1]), 32'h1);
    @(posedge clk); #1 dma_req = 1'b0;
    @(negedge clk);
    chk("abort_issue", 32'(mem_acc_a[1]), 32'h1);
    @(posedge clk); #1;
    @(posedge clk); #1 reset_n = 1'b0;
    #1;
    chk_idle_outputs(1);
    @(posedge clk); #1 reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("abort_no_rvalid", 32'(dma_rvalid_a[1]), 32'h0);
      chk("abort_no_access", 32'(mem_acc_a[1]), 32'h0);
      @(posedge clk); #1;
    end
    run_row(post_rst);

    // three consecutive ties on the MEM_LAT=1 instance, last owner is DMA after reset
    sel = 0;
    cpu_access = 1'b1; cpu_address = 32'h300; cpu_data_we = 4'h0; cpu_data_write = 32'h0;
    dma_req = 1'b1; dma_address = 32'h3A0; dma_we = 4'h0; dma_wdata = 32'h0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("tie_stall", 32'(cpu_stall_a[0]), 32'(tie_stall[c]));
      chk("tie_gnt", 32'(dma_gnt_a[0]), 32'(tie_gnt[c]));
      chk("tie_rvalid", 32'(dma_rvalid_a[0]), 32'(tie_rv[c]));
      if (c == 1 || c == 9) chk("tie_addr_cpu", mem_addr_a[0], 32'h300);
      if (c == 5) chk("tie_addr_mid", mem_addr_a[0], tie_addr5);
      if (!tie_stall[c]) chk("tie_cpu_rdata", cpu_rd_a[0], 32'h0300FCFF);
      if (tie_rv[c]) chk("tie_dma_rdata", dma_rd_a[0], 32'h03A0FC5F);
      @(posedge clk); #1;
    end
    cpu_access = 1'b0; dma_req = 1'b0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
